// File: rtl/dmem_responder.sv
// Data-memory responder for a pipelined core: word-addressed RAM behind a
// fixed-latency stall handshake, with alignment/range checking on every request.
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        addr_err
);
    localparam int         AW       = $clog2(DEPTH);
    localparam bit         ZERO_LAT = (LATENCY == 0);
    localparam logic [3:0] LOAD     = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_reg;
    logic [3:0]    count_reg;
    logic [AW-1:0] cap_idx_reg;
    logic [31:0]   cap_data_reg;
    logic          cap_write_reg;
    logic          addr_err_reg;

    logic [31:0]   mem [DEPTH];

    logic          req;
    logic          addr_ok;
    logic          accept;
    logic          reject;
    logic          done;
    logic          rd_fire;
    logic          wr_fire;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] acc_idx;
    logic [31:0]   wr_data;

    assign req_idx = dataadr[AW+1:2];
    assign addr_ok = (dataadr[1:0] == 2'b00) && (dataadr[31:AW+2] == '0);
    assign req     = !reset && (state_reg == IDLE) && (memwrite || memread);
    assign accept  = req && addr_ok;
    assign reject  = req && !addr_ok;
    assign done    = !reset && (state_reg == BUSY) && (count_reg == 4'd0);

    // Zero latency serves the live request; otherwise only captured values are used.
    always_comb begin
        rd_fire = 1'b0;
        wr_fire = 1'b0;
        acc_idx = cap_idx_reg;
        wr_data = cap_data_reg;
        if (ZERO_LAT) begin
            rd_fire = accept && !memwrite;
            wr_fire = accept && memwrite;
            acc_idx = req_idx;
            wr_data = writedata;
        end else begin
            rd_fire = done && !cap_write_reg;
            wr_fire = done && cap_write_reg;
        end
    end

    assign stall    = !ZERO_LAT &&
                      (accept || (!reset && (state_reg == BUSY) && (count_reg != 4'd0)));
    assign readdata = rd_fire ? mem[acc_idx] : 32'd0;
    assign addr_err = addr_err_reg;

    // Memory is deliberately outside the reset domain: reset never alters contents.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[acc_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= 4'd0;
            cap_idx_reg   <= '0;
            cap_data_reg  <= 32'd0;
            cap_write_reg <= 1'b0;
            addr_err_reg  <= 1'b0;
        end else begin
            addr_err_reg <= reject;
            case (state_reg)
                IDLE: begin
                    if (accept && !ZERO_LAT) begin
                        state_reg     <= BUSY;
                        count_reg     <= LOAD;
                        cap_idx_reg   <= req_idx;
                        cap_data_reg  <= writedata;
                        cap_write_reg <= memwrite;
                    end
                end
                BUSY: begin
                    if (count_reg == 4'd0) begin
                        state_reg <= IDLE;
                    end else begin
                        count_reg <= count_reg - 4'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
